// File: rtl/clk_div_sequencer.sv
// Multi-channel runtime-programmable clock divider with boundary-safe divisor updates.
// Optional phase alignment input enabled by defining CLK_DIV_SEQ_PHASE_ALIGN_EN.
`timescale 1ns/1ps
module clk_div_sequencer #(
  parameter int NCH = 3,
  parameter int DW  = 8
) (
  input  logic           clock_in,
  input  logic           reset,
  input  logic           cfg_valid,
  output logic           cfg_ready,
  input  logic [1:0]     cfg_sel,
  input  logic [DW-1:0]  cfg_div,
`ifdef CLK_DIV_SEQ_PHASE_ALIGN_EN
  input  logic           sync_req,
`endif
  output logic [NCH-1:0] tick,
  output logic [NCH-1:0] clock_out,
  output logic           busy
);

  typedef enum logic {IDLE, WAIT} state_t;

  localparam logic [2:0] NCH_L = 3'(NCH);

  state_t              state_q;
  logic                ready_q;
  logic                busy_q;
  logic [1:0]          pend_sel_q;
  logic [DW-1:0]       pend_div_q;
  logic [DW-1:0]       div_q [NCH];
  logic [DW-1:0]       cnt_q [NCH];
  logic [NCH-1:0]      clk_q;
  logic [NCH-1:0]      wrap;
  logic [NCH-1:0]      apply;
  logic                sync_w;

`ifdef CLK_DIV_SEQ_PHASE_ALIGN_EN
  assign sync_w = sync_req;
`else
  assign sync_w = 1'b0;
`endif

  // An update lands on the target's wrap edge, or immediately if it is idle (div == 0).
  for (genvar gi = 0; gi < NCH; gi++) begin : g_ch
    assign wrap[gi]  = (div_q[gi] != '0) && (cnt_q[gi] == div_q[gi] - DW'(1));
    assign tick[gi]  = wrap[gi] & ~sync_w;
    assign apply[gi] = (state_q == WAIT) && (pend_sel_q == 2'(gi)) &&
                       (wrap[gi] || (div_q[gi] == '0));
  end

  assign clock_out = clk_q;
  assign cfg_ready = ready_q;
  assign busy      = busy_q;

  always_ff @(posedge clock_in) begin
    if (reset) begin
      for (int c = 0; c < NCH; c++) begin
        div_q[c] <= '0;
        cnt_q[c] <= '0;
      end
      clk_q <= '0;
    end else begin
      for (int c = 0; c < NCH; c++) begin
        if (apply[c])
          div_q[c] <= pend_div_q;

        if (sync_w || apply[c] || wrap[c] || (div_q[c] == '0))
          cnt_q[c] <= '0;
        else
          cnt_q[c] <= cnt_q[c] + DW'(1);

        // Disabling forces the output low rather than leaving it mid-phase.
        if (sync_w)
          clk_q[c] <= 1'b0;
        else if (apply[c] && (pend_div_q == '0))
          clk_q[c] <= 1'b0;
        else if (wrap[c])
          clk_q[c] <= ~clk_q[c];
        else if (div_q[c] == '0)
          clk_q[c] <= 1'b0;
      end
    end
  end

  always_ff @(posedge clock_in) begin
    if (reset) begin
      state_q    <= IDLE;
      ready_q    <= 1'b1;
      busy_q     <= 1'b0;
      pend_sel_q <= '0;
      pend_div_q <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (cfg_valid && ready_q) begin
            pend_sel_q <= cfg_sel;
            pend_div_q <= cfg_div;
            // Requests for nonexistent channels are accepted and silently dropped.
            if ({1'b0, cfg_sel} < NCH_L) begin
              state_q <= WAIT;
              ready_q <= 1'b0;
              busy_q  <= 1'b1;
            end
          end
        end
        WAIT: begin
          if (|apply) begin
            state_q <= IDLE;
            ready_q <= 1'b1;
            busy_q  <= 1'b0;
          end
        end
        default: begin
          state_q <= IDLE;
          ready_q <= 1'b1;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_clk_div_sequencer.sv
// Directed bench for clk_div_sequencer; expected values are worked out by hand per step.
`timescale 1ns/1ps
module tb_clk_div_sequencer;

  localparam int NCH = 3;
  localparam int DW  = 8;

  logic           clock_in = 1'b0;
  logic           reset;
  logic           cfg_valid;
  logic           cfg_ready;
  logic [1:0]     cfg_sel;
  logic [DW-1:0]  cfg_div;
  logic [NCH-1:0] tick;
  logic [NCH-1:0] clock_out;
  logic           busy;
`ifdef CLK_DIV_SEQ_PHASE_ALIGN_EN
  logic           sync_req;
`endif

  int nvec = 0;
  int nerr = 0;
  logic acc;

  clk_div_sequencer #(.NCH(NCH), .DW(DW)) dut (
    .clock_in  (clock_in),
    .reset     (reset),
    .cfg_valid (cfg_valid),
    .cfg_ready (cfg_ready),
    .cfg_sel   (cfg_sel),
    .cfg_div   (cfg_div),
`ifdef CLK_DIV_SEQ_PHASE_ALIGN_EN
    .sync_req  (sync_req),
`endif
    .tick      (tick),
    .clock_out (clock_out),
    .busy      (busy)
  );

  always #5 clock_in = ~clock_in;

  task automatic step();
    @(posedge clock_in);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nvec++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
    $display("vec %0d %s observed %0h expected %0h", nvec, tag, obs, exp);
  endtask

  initial begin
    reset = 1'b1; cfg_valid = 1'b0; cfg_sel = '0; cfg_div = '0;
`ifdef CLK_DIV_SEQ_PHASE_ALIGN_EN
    sync_req = 1'b0;
`endif
    step(); step();
    chk("rst_clock_out", 32'(clock_out), 0);
    chk("rst_tick", 32'(tick), 0);
    chk("rst_ready", 32'(cfg_ready), 1);
    chk("rst_busy", 32'(busy), 0);
    reset = 1'b0;

    // ch0 div=3 from disabled: applies one edge after acceptance
    cfg_sel = 2'd0; cfg_div = 8'd3; cfg_valid = 1'b1;
    step(); cfg_valid = 1'b0;
    chk("t1_ready_low", 32'(cfg_ready), 0);
    chk("t1_busy_high", 32'(busy), 1);
    step();
    chk("t1_ready_back", 32'(cfg_ready), 1);
    chk("t1_busy_low", 32'(busy), 0);
    for (int k = 0; k <= 6; k++) begin
      if (k > 0) step();
      chk($sformatf("t1_tick0_k%0d", k), 32'(tick[0]), 32'((k % 3) == 2));
      chk($sformatf("t1_clk0_k%0d", k), 32'(clock_out[0]), 32'((k / 3) % 2));
    end

    // ch1 div=4, then rewrite to 2 while cnt=1
    cfg_sel = 2'd1; cfg_div = 8'd4; cfg_valid = 1'b1;
    step(); cfg_valid = 1'b0;
    step();                       // applied, cnt1=0
    step();                       // cnt1=1
    cfg_sel = 2'd1; cfg_div = 8'd2; cfg_valid = 1'b1;
    step(); cfg_valid = 1'b0;     // accepted, cnt1=2
    chk("t2_busy_a", 32'(busy), 1);
    step();                       // cnt1=3, wrap pending
    chk("t2_busy_b", 32'(busy), 1);
    chk("t2_tick1_wrap", 32'(tick[1]), 1);
    chk("t2_clk1_prewrap", 32'(clock_out[1]), 0);
    step();                       // apply edge
    chk("t2_busy_done", 32'(busy), 0);
    for (int k = 0; k <= 4; k++) begin
      if (k > 0) step();
      chk($sformatf("t2_clk1_k%0d", k), 32'(clock_out[1]), 32'(((k / 2) % 2) == 0));
      chk($sformatf("t2_tick1_k%0d", k), 32'(tick[1]), 32'((k % 2) == 1));
    end

    // ch2 div=5, then disable it mid-period
    cfg_sel = 2'd2; cfg_div = 8'd5; cfg_valid = 1'b1;
    step(); cfg_valid = 1'b0;
    step();                       // applied, cnt2=0
    repeat (7) step();            // cnt2=2, one toggle done
    chk("t3_clk2_running", 32'(clock_out[2]), 1);
    cfg_sel = 2'd2; cfg_div = 8'd0; cfg_valid = 1'b1;
    step(); cfg_valid = 1'b0;     // cnt2=3
    chk("t3_busy", 32'(busy), 1);
    step();                       // cnt2=4
    chk("t3_tick2_last", 32'(tick[2]), 1);
    chk("t3_clk2_before", 32'(clock_out[2]), 1);
    step();
    chk("t3_clk2_forced", 32'(clock_out[2]), 0);
    chk("t3_busy_done", 32'(busy), 0);
    acc = 1'b0;
    repeat (12) begin
      step();
      acc = acc | tick[2] | clock_out[2];
    end
    chk("t3_ch2_quiet", 32'(acc), 0);

    // Out-of-range channel select is dropped
    cfg_sel = 2'd3; cfg_div = 8'd9; cfg_valid = 1'b1;
    step(); cfg_valid = 1'b0;
    chk("t4_busy", 32'(busy), 0);
    chk("t4_ready", 32'(cfg_ready), 1);
    step();
    chk("t4_busy_next", 32'(busy), 0);
    chk("t4_clk2_still_off", 32'(clock_out[2]), 0);

    // Reset while an update is pending
    cfg_sel = 2'd0; cfg_div = 8'd7; cfg_valid = 1'b1;
    step(); cfg_valid = 1'b0;
    chk("t5_busy", 32'(busy), 1);
    reset = 1'b1;
    step();
    chk("t5_clock_out", 32'(clock_out), 0);
    chk("t5_tick", 32'(tick), 0);
    chk("t5_ready", 32'(cfg_ready), 1);
    chk("t5_busy_low", 32'(busy), 0);
    reset = 1'b0;
    acc = 1'b0;
    repeat (10) begin
      step();
      acc = acc | (|clock_out) | (|tick) | busy;
    end
    chk("t5_all_disabled", 32'(acc), 0);

`ifdef CLK_DIV_SEQ_PHASE_ALIGN_EN
    cfg_sel = 2'd0; cfg_div = 8'd2; cfg_valid = 1'b1;
    step(); cfg_valid = 1'b0; step();
    cfg_sel = 2'd1; cfg_div = 8'd3; cfg_valid = 1'b1;
    step(); cfg_valid = 1'b0; step();
    repeat (3) step();
    sync_req = 1'b1;
    #1;
    chk("t6_tick_during_sync", 32'(tick), 0);
    step();
    sync_req = 1'b0;
    chk("t6_clk_aligned", 32'(clock_out[1:0]), 0);
    for (int k = 1; k <= 6; k++) begin
      step();
      chk($sformatf("t6_clk0_k%0d", k), 32'(clock_out[0]), 32'((k / 2) % 2));
      chk($sformatf("t6_clk1_k%0d", k), 32'(clock_out[1]), 32'((k / 3) % 2));
    end
`endif

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
